// File: rtl/mem_stage_pkg.sv
// MEM stage bus layouts; widths come from the shared pipeline width macros.
`define EXE_TO_MEM_WD 71
`define MEM_TO_WB_WD 70
`define MEM_FWD_WD 38

package mem_stage_pkg;
  localparam int EXE_W = `EXE_TO_MEM_WD;
  localparam int WB_W  = `MEM_TO_WB_WD;
  localparam int FWD_W = `MEM_FWD_WD;

  typedef struct packed {
    logic        regw;
    logic [4:0]  waddr;
    logic        res_from_mem;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } exe_bus_t;

  typedef struct packed {
    logic        regw;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [31:0] pc;
  } wb_bus_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  waddr;
    logic [31:0] result;
  } fwd_bus_t;
endpackage

// File: rtl/mem_rdata_hold.sv
// Keeps a load's first-cycle SRAM read data alive while WB back-pressures.
module mem_rdata_hold (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        first,
  input  logic        stall,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        sel
);
  logic [31:0] rdata_hold;
  logic        hold_valid;

  // A new instruction always invalidates the hold, even if a latch is requested.
  always_ff @(posedge clk) begin
    if (reset)                hold_valid <= 1'b0;
    else if (capture)         hold_valid <= 1'b0;
    else if (first && stall)  hold_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (first && stall) rdata_hold <= rdata;
  end

  assign data = rdata_hold;
  assign sel  = hold_valid;
endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: registers EXE results, merges load data, feeds WB.
// Optional bypass output to ID is built only with MEM_FWD_EN defined.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             mem_allowin,
  input  logic             exe_to_mem_valid,
  input  logic [EXE_W-1:0] exe_to_mem_bus,
  input  logic             wb_allowin,
  output logic             mem_to_wb_valid,
  output logic [WB_W-1:0]  mem_to_wb_bus,
  input  logic [31:0]      data_sram_rdata,
  output logic [FWD_W-1:0] mem_fwd_bus
);
  logic        mem_valid;
  logic        first_cycle;
  logic        mem_ready_go;
  logic        capture;
  logic        hold_sel;
  logic [31:0] hold_data;
  logic [31:0] final_result;
  exe_bus_t    mem_data;
  wb_bus_t     wb_bus;

  assign mem_ready_go    = 1'b1;
  assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go;
  assign capture         = mem_allowin & exe_to_mem_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid   <= 1'b0;
      first_cycle <= 1'b0;
    end else begin
      if (mem_allowin) mem_valid <= exe_to_mem_valid;
      first_cycle <= capture;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem_data <= exe_bus_t'(exe_to_mem_bus);
  end

  // SRAM read data belongs to us only in the first resident cycle.
  mem_rdata_hold u_hold (
    .clk     (clk),
    .reset   (reset),
    .capture (capture),
    .first   (mem_valid & first_cycle & mem_data.res_from_mem),
    .stall   (~wb_allowin),
    .rdata   (data_sram_rdata),
    .data    (hold_data),
    .sel     (hold_sel)
  );

  assign final_result = mem_data.res_from_mem ? (hold_sel ? hold_data : data_sram_rdata)
                                              : mem_data.alu_result;

  always_comb begin
    wb_bus        = '0;
    wb_bus.regw   = mem_data.regw;
    wb_bus.waddr  = mem_data.waddr;
    wb_bus.result = final_result;
    wb_bus.pc     = mem_data.pc;
  end
  assign mem_to_wb_bus = wb_bus;

`ifdef MEM_FWD_EN
  fwd_bus_t fwd;
  always_comb begin
    fwd        = '0;
    fwd.valid  = mem_valid & mem_data.regw & (mem_data.waddr != 5'd0);
    fwd.waddr  = mem_data.waddr;
    fwd.result = final_result;
  end
  assign mem_fwd_bus = fwd;
`else
  assign mem_fwd_bus = '0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with directed corner sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             mem_allowin;
  logic             exe_to_mem_valid = 1'b0;
  logic [EXE_W-1:0] exe_to_mem_bus = '0;
  logic             wb_allowin = 1'b1;
  logic             mem_to_wb_valid;
  logic [WB_W-1:0]  mem_to_wb_bus;
  logic [31:0]      data_sram_rdata = '0;
  logic [FWD_W-1:0] mem_fwd_bus;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .data_sram_rdata  (data_sram_rdata),
    .mem_fwd_bus      (mem_fwd_bus)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       passed = 0;
  wb_bus_t  q[$];
  exe_bus_t pend = '0;
  logic [31:0] pend_ld = '0;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  function automatic exe_bus_t mk(input logic regw, input logic [4:0] wa, input logic ld,
                                  input logic [31:0] alu, input logic [31:0] pc);
    exe_bus_t b;
    b.regw = regw; b.waddr = wa; b.res_from_mem = ld; b.alu_result = alu; b.pc = pc;
    return b;
  endfunction

  // One cycle: learn whether the offered instruction was taken, then drive the next cycle.
  task automatic step(input logic v, input exe_bus_t b, input logic [31:0] ld,
                      input logic wba, input logic [31:0] junk);
    logic    fire;
    wb_bus_t e;
    @(negedge clk);
    fire = exe_to_mem_valid & mem_allowin;
    @(posedge clk); #1;
    if (fire) begin
      e.regw   = pend.regw;
      e.waddr  = pend.waddr;
      e.result = pend.res_from_mem ? pend_ld : pend.alu_result;
      e.pc     = pend.pc;
      q.push_back(e);
      data_sram_rdata = pend_ld;
    end else begin
      data_sram_rdata = junk;
    end
    exe_to_mem_valid = v;
    exe_to_mem_bus   = b;
    pend             = b;
    pend_ld          = ld;
    wb_allowin       = wba;
  endtask

  task automatic do_reset(input logic wba);
    step(1'b0, '0, '0, wba, $urandom);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic chk_idle(input string nm);
    @(negedge clk);
    chk({nm, "_allowin"}, 70'(mem_allowin), 70'd1);
    chk({nm, "_valid"}, 70'(mem_to_wb_valid), 70'd0);
    chk({nm, "_fwd_valid"}, 70'(mem_fwd_bus[FWD_W-1]), 70'd0);
    chk({nm, "_hold"}, 70'(dut.hold_sel), 70'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("allowin", 70'(mem_allowin), 70'(!mem_to_wb_valid | wb_allowin));
      if (mem_to_wb_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output actual=%h required=none", mem_to_wb_bus);
        end else begin
          chk("wb_bus", 70'(mem_to_wb_bus), 70'(q[0]));
`ifdef MEM_FWD_EN
          chk("fwd_bus", 70'(mem_fwd_bus),
              70'({q[0].regw & (q[0].waddr != 5'd0), q[0].waddr, q[0].result}));
`else
          chk("fwd_bus", 70'(mem_fwd_bus), 70'd0);
`endif
          if (wb_allowin) void'(q.pop_front());
        end
      end else begin
`ifdef MEM_FWD_EN
        chk("fwd_idle", 70'(mem_fwd_bus[FWD_W-1]), 70'd0);
`else
        chk("fwd_idle", 70'(mem_fwd_bus), 70'd0);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(1'b1);
    chk_idle("reset");

    // back-to-back ALU ops
    step(1, mk(1, 5'd3, 0, 32'h0000_1234, 32'h1C00_0000), 0, 1, $urandom);
    step(1, mk(1, 5'd4, 0, 32'h0000_5678, 32'h1C00_0004), 0, 1, $urandom);
    // load without stall
    step(1, mk(1, 5'd7, 1, 32'h0000_0010, 32'h1C00_0008), 32'hDEAD_BEEF, 1, $urandom);
    // load stalled 3 cycles; SRAM data changes underneath it
    step(1, mk(1, 5'd9, 1, 32'h0000_0020, 32'h1C00_000C), 32'hCAFE_0001, 1, $urandom);
    step(0, '0, 0, 0, 32'h1111_1111);
    step(0, '0, 0, 0, 32'h0000_0000);
    step(0, '0, 0, 0, 32'hFFFF_FFFF);
    // release: ALU op offered and captured at the release edge
    step(1, mk(1, 5'd10, 0, 32'hA5A5_0000, 32'h1C00_0010), 0, 1, 32'h2222_2222);
    step(0, '0, 0, 1, 32'h3333_3333);
    @(negedge clk);
    chk("release_hold", 70'(dut.hold_sel), 70'd0);
    chk("release_result", 70'(mem_to_wb_bus[63:32]), 70'(32'hA5A5_0000));

    // forwarding: x0 suppressed, x5 forwarded
    step(1, mk(1, 5'd0, 0, 32'h0BAD_0000, 32'h1C00_0014), 0, 1, $urandom);
    step(1, mk(1, 5'd5, 0, 32'h0000_0555, 32'h1C00_0018), 0, 1, $urandom);
    step(0, '0, 0, 1, $urandom);
    step(0, '0, 0, 1, $urandom);

    // reset during a stalled load
    step(1, mk(1, 5'd6, 1, 32'h0, 32'h1C00_001C), 32'h7777_0001, 0, $urandom);
    step(0, '0, 0, 0, 32'h0);
    step(0, '0, 0, 0, 32'h0);
    do_reset(1'b0);
    chk_idle("midstall_reset");
    // a fresh stalled load must not see stale hold data
    step(1, mk(1, 5'd8, 1, 32'h0, 32'h1C00_0020), 32'h0123_4567, 0, $urandom);
    step(0, '0, 0, 0, 32'h89AB_CDEF);
    step(0, '0, 0, 0, 32'h0);
    step(0, '0, 0, 1, 32'h0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           mk($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              $urandom_range(0, 1), $urandom, $urandom),
           $urandom, $urandom_range(0, 2) != 0, $urandom);
    end
    for (int i = 0; i < 8; i++) step(0, '0, 0, 1, $urandom);
    @(negedge clk);
    chk("drained", 70'(q.size()), 70'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
